// File: rtl/seg_scan_if.sv
// seg_scan_if: host-side load bus and display outputs of the seven-segment scan controller
interface seg_scan_if;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  en_in;
  logic        lz_blank_in;
  logic        pending;
  logic [7:0]  seg;
  logic [7:0]  sel;
  logic        frame_start;
  modport master (output load, data_in, dp_in, en_in, lz_blank_in,
                  input  pending, seg, sel, frame_start);
  modport slave  (input  load, data_in, dp_in, en_in, lz_blank_in,
                  output pending, seg, sel, frame_start);
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit seven-segment scanner; updates are double-buffered and committed only at frame boundaries
module seg_scan_ctrl #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int SCAN_FREQ  = 1000
) (
  input  logic clk,
  input  logic reset,
  seg_scan_if.slave bus
);
  localparam int MCNT = CLOCK_FREQ / SCAN_FREQ - 1;
  localparam int CW = MCNT > 0 ? $clog2(MCNT + 1) : 1;
  localparam logic [15:0][6:0] HEX7 = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                       7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

  function automatic logic [2:0] lsb(input logic [7:0] v);
    lsb = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) lsb = 3'(i);
  endfunction

  logic [CW-1:0] cnt;
  logic [31:0] p_data, a_data, n_data;
  logic [7:0] p_dp, p_en, a_dp, a_en, n_dp, n_en, above;
  logic p_lz, a_lz, n_lz;
  logic [2:0] idx, nidx;
  logic [3:0] nib;
  logic tick, commit, wrap, blank;

  assign tick = cnt == CW'(MCNT);
  // The last enabled digit of the frame is the only point where new data may take over
  assign commit = tick && bus.pending && (a_en == 8'h00 || (a_en >> idx) == 8'h01);
  assign n_data = commit ? (bus.load ? bus.data_in : p_data) : a_data;
  assign n_dp = commit ? (bus.load ? bus.dp_in : p_dp) : a_dp;
  assign n_en = commit ? (bus.load ? bus.en_in : p_en) : a_en;
  assign n_lz = commit ? (bus.load ? bus.lz_blank_in : p_lz) : a_lz;
  assign above = n_en & (8'hFE << idx);
  assign wrap = commit || above == 8'h00;
  assign nidx = lsb(wrap ? n_en : above);
  assign nib = 4'(n_data >> {nidx, 2'b00});
  assign blank = n_lz && nidx != 3'd0 && !n_dp[nidx] && (n_data >> {nidx, 2'b00}) == 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      {p_data, p_dp, p_en, p_lz} <= '0;
      {a_data, a_dp, a_en, a_lz} <= '0;
      idx <= '0;
      bus.pending <= 1'b0;
      bus.seg <= 8'hFF;
      bus.sel <= 8'h00;
      bus.frame_start <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      bus.frame_start <= 1'b0;
      if (commit) begin
        {a_data, a_dp, a_en, a_lz} <= {n_data, n_dp, n_en, n_lz};
        bus.pending <= 1'b0;
      end else if (bus.load) begin
        {p_data, p_dp, p_en, p_lz} <= {bus.data_in, bus.dp_in, bus.en_in, bus.lz_blank_in};
        bus.pending <= 1'b1;
      end
      if (tick) begin
        idx <= nidx;
        bus.sel <= n_en == 8'h00 ? 8'h00 : 8'h01 << nidx;
        bus.seg <= (n_en == 8'h00 || blank) ? 8'hFF : {~n_dp[nidx], HEX7[nib]};
        bus.frame_start <= n_en != 8'h00 && wrap;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan order, tear-free commit, blanking and corner masks (tick every 10 clk)
module tb_seg_scan_ctrl;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  int fsn;
  logic [7:0] t1 [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
  logic [7:0] t4 [8] = '{8'h92, 8'hC0, 8'h30, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] t4b [8] = '{8'h92, 8'hC0, 8'h30, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};

  seg_scan_if bus();
  seg_scan_ctrl #(.CLOCK_FREQ(100), .SCAN_FREQ(10)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ld(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en, input logic lz);
    bus.data_in = d;
    bus.dp_in = dp;
    bus.en_in = en;
    bus.lz_blank_in = lz;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.frame_start && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.frame_start), 32'd1);
  endtask

  task automatic out(input string tag, input logic [7:0] sel, input logic [7:0] seg, input logic fs);
    chk({tag, "_sel"}, 32'(bus.sel), 32'(sel));
    chk({tag, "_seg"}, 32'(bus.seg), 32'(seg));
    chk({tag, "_fs"}, 32'(bus.frame_start), 32'(fs));
  endtask

  initial begin
    bus.load = 1'b0;
    bus.data_in = '0;
    bus.dp_in = '0;
    bus.en_in = '0;
    bus.lz_blank_in = 1'b0;
    reset = 1'b1;
    adv(2);
    out("rst", 8'h00, 8'hFF, 1'b0);
    chk("rst_pend", 32'(bus.pending), 32'd0);
    reset = 1'b0;
    ld(32'h76543210, 8'h00, 8'hFF, 1'b0);
    chk("t1_pend", 32'(bus.pending), 32'd1);
    wait_frame("t1_start");
    out("t1_d0", 8'h01, 8'hC0, 1'b1);
    chk("t1_pend0", 32'(bus.pending), 32'd0);
    for (int i = 1; i < 8; i++) begin
      adv(10);
      out($sformatf("t1_d%0d", i), 8'(1 << i), t1[i], 1'b0);
    end
    adv(10);
    out("t1_wrap", 8'h01, 8'hC0, 1'b1);
    ld(32'h76543210, 8'h00, 8'hA5, 1'b0);
    wait_frame("t2_start");
    out("t2_d0", 8'h01, 8'hC0, 1'b1);
    adv(9);
    out("t2_dwell", 8'h01, 8'hC0, 1'b0);
    adv(1);
    out("t2_d2", 8'h04, 8'hA4, 1'b0);
    adv(10);
    out("t2_d5", 8'h20, 8'h92, 1'b0);
    adv(10);
    out("t2_d7", 8'h80, 8'hF8, 1'b0);
    adv(10);
    out("t2_wrap", 8'h01, 8'hC0, 1'b1);
    ld(32'h22222222, 8'h00, 8'hFF, 1'b0);
    wait_frame("t3_start");
    out("t3_d0", 8'h01, 8'hA4, 1'b1);
    adv(10);
    out("t3_d1", 8'h02, 8'hA4, 1'b0);
    ld(32'h11111111, 8'h00, 8'hFF, 1'b0);
    chk("t3_pend", 32'(bus.pending), 32'd1);
    adv(9);
    out("t3_d2", 8'h04, 8'hA4, 1'b0);
    for (int i = 3; i < 8; i++) begin
      adv(10);
      out($sformatf("t3_d%0d", i), 8'(1 << i), 8'hA4, 1'b0);
    end
    adv(9);
    chk("t3_pend7", 32'(bus.pending), 32'd1);
    adv(1);
    out("t3_new", 8'h01, 8'hF9, 1'b1);
    chk("t3_pend0", 32'(bus.pending), 32'd0);
    adv(10);
    out("t3_new1", 8'h02, 8'hF9, 1'b0);
    ld(32'h00000305, 8'h04, 8'hFF, 1'b1);
    wait_frame("t4_start");
    out("t4_d0", 8'h01, t4[0], 1'b1);
    for (int i = 1; i < 8; i++) begin
      adv(10);
      out($sformatf("t4_d%0d", i), 8'(1 << i), t4[i], 1'b0);
    end
    ld(32'h00000305, 8'h04, 8'hFF, 1'b0);
    wait_frame("t4b_start");
    out("t4b_d0", 8'h01, t4b[0], 1'b1);
    for (int i = 1; i < 8; i++) begin
      adv(10);
      out($sformatf("t4b_d%0d", i), 8'(1 << i), t4b[i], 1'b0);
    end
    ld(32'h00000000, 8'h00, 8'h00, 1'b0);
    adv(9);
    out("t5_off", 8'h00, 8'hFF, 1'b0);
    chk("t5_pend", 32'(bus.pending), 32'd0);
    fsn = 0;
    repeat (30) begin
      @(negedge clk);
      fsn += int'(bus.frame_start);
    end
    chk("t5_nofs", 32'(fsn), 32'd0);
    chk("t5_sel", 32'(bus.sel), 32'd0);
    ld(32'h00050000, 8'h00, 8'h10, 1'b0);
    wait_frame("t5_start");
    out("t5_d4", 8'h10, 8'h92, 1'b1);
    adv(10);
    out("t5_d4b", 8'h10, 8'h92, 1'b1);
    adv(5);
    out("t5_hold", 8'h10, 8'h92, 1'b0);
    ld(32'h0000000A, 8'h00, 8'h01, 1'b0);
    chk("t6_pend", 32'(bus.pending), 32'd1);
    adv(3);
    ld(32'h0000000C, 8'h00, 8'h01, 1'b0);
    out("t6_sim", 8'h01, 8'hC6, 1'b1);
    chk("t6_pend0", 32'(bus.pending), 32'd0);
    adv(4);
    ld(32'h12345678, 8'h00, 8'hFF, 1'b0);
    chk("t6_pend1", 32'(bus.pending), 32'd1);
    reset = 1'b1;
    #1;
    out("t6_rst", 8'h00, 8'hFF, 1'b0);
    chk("t6_rst_pend", 32'(bus.pending), 32'd0);
    adv(2);
    reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
